// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver, the receive-side partner of the uart transmitter
// on clk_sys.
//
// Each received byte is held in data_o. valid_o stays high until the consumer
// acknowledges the byte. overrun_o and frame_err_o report lost or bad frames.
//
// Optional feature macro: UART_RX_PARITY_EN
//   When defined, an even-parity bit is expected between bit 7 and the stop
//   bit, and the parity_err_o port is present.
//   When undefined, the frame is plain 8N1 and the port does not exist.
//
// Parameters
//   CLK_FREQ_HZ  system clock frequency in Hz
//   BAUDRATE     line rate in bit/s
//   DIV = round(CLK_FREQ_HZ / BAUDRATE) clocks per bit (must be >= 2)
//
// Ports
//   clk_i         system clock (clk_sys)
//   rst_ni        asynchronous active-low reset
//   uart_rx_i     asynchronous serial line, idle high
//   rx_ack_i      1-cycle strobe: consumer has read data_o
//   data_o        last received byte
//   valid_o       level: data_o holds an unread byte
//   overrun_o     sticky: a byte was overwritten before being acked
//   frame_err_o   1-cycle strobe: stop bit sampled low
//   parity_err_o  1-cycle strobe: parity mismatch (UART_RX_PARITY_EN only)
//   busy_o        receiver is not idle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx #(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int BAUDRATE    = 115_200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       uart_rx_i,
  input  logic       rx_ack_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       overrun_o,
  output logic       frame_err_o,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err_o,
`endif
  output logic       busy_o
);

  localparam int DIV   = (CLK_FREQ_HZ + BAUDRATE / 2) / BAUDRATE;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = (DIV >= 2) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_rx: CLK_FREQ_HZ/BAUDRATE gives fewer than 2 clocks per bit");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic parity_fail(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [1:0]       settle_q;

  logic rx_sync_p0, rx_s, rx_d;
  logic settled, fall, tick;

  logic ld_half, ld_full, shift_en, load_byte, ferr_set;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_en, stop_smp;
`endif

  // ---- input synchronizer and edge detect ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_sync_p0 <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
    end else begin
      rx_sync_p0 <= uart_rx_i;
      rx_s       <= rx_sync_p0;
      rx_d       <= rx_s;
    end
  end

  // After reset the synchronizer holds preset ones rather than pin samples.
  // Edges are ignored until all three flops carry real samples, so a line
  // that is already low at reset release is not mistaken for a start edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               settle_q <= 2'd0;
    else if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
  end

  assign settled = (settle_q == 2'd3);
  assign fall    = settled & rx_d & ~rx_s;
  assign tick    = (cnt_q == '0);

  // ---- receive FSM ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ld_half   = 1'b0;
    ld_full   = 1'b0;
    shift_en  = 1'b0;
    load_byte = 1'b0;
    ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
    stop_smp  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          ld_half = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            ld_full = 1'b1;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          ld_full  = 1'b1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          par_en  = 1'b1;
          ld_full = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
`ifdef UART_RX_PARITY_EN
          stop_smp = 1'b1;
`endif
          if (rx_s) begin
            load_byte = 1'b1;
            state_d   = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_WAIT_IDLE;
          end
        end
      end
      // A held-low line (break) must return high before a new start edge
      // can be recognised.
      S_WAIT_IDLE: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---- bit timing and index ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      idx_q <= 3'd0;
    end else begin
      if (ld_half)      cnt_q <= CNT_HALF;
      else if (ld_full) cnt_q <= CNT_FULL;
      else if (!tick)   cnt_q <= cnt_q - 1'b1;

      if (state_q == S_START) idx_q <= 3'd0;
      else if (shift_en)      idx_q <= idx_q + 3'd1;
    end
  end

  // ---- data capture (no reset on datapath) ----
  always_ff @(posedge clk_i) begin
    if (shift_en) shift_q <= {rx_s, shift_q[7:1]};
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (par_en) par_q <= rx_s;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) parity_err_o <= 1'b0;
    else         parity_err_o <= stop_smp & parity_fail(shift_q, par_q);
  end
`endif

  // ---- output register and handshake ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      overrun_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= ferr_set;
      if (load_byte) begin
        data_o  <= shift_q;
        valid_o <= 1'b1;
        // An ack in the same cycle consumes the old byte, so no overrun.
        if (rx_ack_i)     overrun_o <= 1'b0;
        else if (valid_o) overrun_o <= 1'b1;
      end else if (rx_ack_i && valid_o) begin
        valid_o   <= 1'b0;
        overrun_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx : self-checking bench for uart_rx at DIV=16 (25 MHz, 1.5625 Mbd).
// Frames are driven on the pin in real time. A frame-level reference model
// tracks the expected data/valid/overrun and the error-pulse counts.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_FREQ_HZ = 25_000_000;
  localparam int BAUDRATE    = 1_562_500;
  localparam int DIV         = 16;
  localparam int HALF        = DIV / 2;
  localparam int CLK_NS      = 40;
  localparam int BIT_NS      = DIV * CLK_NS;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS    = 1;
`else
  localparam int PAR_BITS    = 0;
`endif
  // start edge to valid_o visible: sync (3) + mid-bit (HALF) + 9 bit periods
  localparam int LAT_MAX     = 3 + (9 + PAR_BITS) * DIV + HALF;
  localparam int LOAD_EDGE   = 2 + HALF + (9 + PAR_BITS) * DIV;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       uart_rx_i = 1'b1;
  logic       rx_ack_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, overrun_o, frame_err_o, busy_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

  uart_rx #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUDRATE    (BAUDRATE)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .uart_rx_i   (uart_rx_i),
    .rx_ack_i    (rx_ack_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .overrun_o   (overrun_o),
    .frame_err_o (frame_err_o),
`ifdef UART_RX_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .busy_o      (busy_o)
  );

  always #(CLK_NS / 2) clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe monitors: count cycles each strobe is high.
  int fe_cycles = 0;
  int pe_cycles = 0;
  always @(negedge clk_i) begin
    if (frame_err_o === 1'b1) fe_cycles++;
`ifdef UART_RX_PARITY_EN
    if (parity_err_o === 1'b1) pe_cycles++;
`endif
  end

  // ---- frame-level reference model ----
  logic [7:0] m_data  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ovr   = 1'b0;
  int         m_fe    = 0;
  int         m_pe    = 0;

  function automatic void model_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    if (!par_ok) m_pe++;
    if (stop_ok) begin
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = b;
    end else begin
      m_fe++;
    end
  endfunction

  function automatic void model_ack();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endfunction

  // Drive one frame. The line is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input int bit_ns,
                            input bit par_flip);
    uart_rx_i = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i];
      #(bit_ns);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx_i = (^b) ^ par_flip;
    #(bit_ns);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    uart_rx_i = stop_bit;
    #(bit_ns);
  endtask

  task automatic do_ack();
    @(negedge clk_i);
    rx_ack_i = 1'b1;
    @(negedge clk_i);
    rx_ack_i = 1'b0;
    model_ack();
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".data"},    data_o,    m_data);
    check_eq({tag, ".valid"},   valid_o,   m_valid);
    check_eq({tag, ".overrun"}, overrun_o, m_ovr);
    check_eq({tag, ".fe_cnt"},  fe_cycles, m_fe);
`ifdef UART_RX_PARITY_EN
    check_eq({tag, ".pe_cnt"},  pe_cycles, m_pe);
`endif
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] b;
    bit stop_ok, flip;
    int bns;

    // ---- reset state ----
    repeat (3) @(negedge clk_i);
    check_eq("rst.data",    data_o,      8'h00);
    check_eq("rst.valid",   valid_o,     1'b0);
    check_eq("rst.overrun", overrun_o,   1'b0);
    check_eq("rst.fe",      frame_err_o, 1'b0);
    check_eq("rst.busy",    busy_o,      1'b0);
    rst_ni = 1'b1;
    repeat (6) @(negedge clk_i);

    // ---- ideal 0x55 frame with latency bound ----
    @(negedge clk_i);
    lat = -1;
    fork
      send_frame(8'h55, 1'b1, BIT_NS, 1'b0);
      begin
        for (int k = 1; k <= LAT_MAX + 20; k++) begin
          @(negedge clk_i);
          if (valid_o === 1'b1 && lat < 0) lat = k;
        end
      end
    join
    check_eq("t1.latency_in_bound", (lat > 0 && lat <= LAT_MAX), 1'b1);
    model_frame(8'h55, 1'b1, 1'b1);
    check_outputs("t1");
    do_ack();
    check_eq("t1.valid_after_ack", valid_o, m_valid);

    // ---- back-to-back 0xA5, 0x3C without ack -> overrun ----
    @(negedge clk_i);
    send_frame(8'hA5, 1'b1, BIT_NS, 1'b0);
    send_frame(8'h3C, 1'b1, BIT_NS, 1'b0);
    repeat (4) @(negedge clk_i);
    model_frame(8'hA5, 1'b1, 1'b1);
    model_frame(8'h3C, 1'b1, 1'b1);
    check_outputs("t2");
    do_ack();
    check_outputs("t2.ack");

    // ---- byte completes in the same cycle as an ack ----
    send_frame(8'h11, 1'b1, BIT_NS, 1'b0);
    repeat (4) @(negedge clk_i);
    model_frame(8'h11, 1'b1, 1'b1);
    check_outputs("t2c.pre");
    @(negedge clk_i);
    fork
      send_frame(8'h99, 1'b1, BIT_NS, 1'b0);
      begin
        repeat (LOAD_EDGE) @(negedge clk_i);
        rx_ack_i = 1'b1;
        @(negedge clk_i);
        rx_ack_i = 1'b0;
      end
    join
    repeat (4) @(negedge clk_i);
    m_data = 8'h99; m_valid = 1'b1; m_ovr = 1'b0;
    check_outputs("t2c");
    do_ack();

    // ---- 0x81 with stop bit low, line held low (break) ----
    send_frame(8'h81, 1'b0, BIT_NS, 1'b0);
    model_frame(8'h81, 1'b0, 1'b1);
    repeat (12) @(negedge clk_i);
    check_eq("t3.busy_wait_idle", busy_o, 1'b1);
    check_outputs("t3");
    uart_rx_i = 1'b1;
    repeat (5) @(negedge clk_i);
    check_eq("t3.busy_released", busy_o, 1'b0);
    send_frame(8'h42, 1'b1, BIT_NS, 1'b0);
    repeat (4) @(negedge clk_i);
    model_frame(8'h42, 1'b1, 1'b1);
    check_outputs("t3.next");
    do_ack();

    // ---- 4-cycle glitch on idle line ----
    @(negedge clk_i);
    uart_rx_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check_eq("t4.busy_in_glitch", busy_o, 1'b1);
    uart_rx_i = 1'b1;
    repeat (HALF + 3 - 4) @(negedge clk_i);
    check_eq("t4.busy_cleared", busy_o, 1'b0);
    repeat (DIV * 12) @(negedge clk_i);
    check_outputs("t4");

    // ---- reset during bit 3 of 0xF0, then 0x0F ----
    send_frame(8'h5A, 1'b1, BIT_NS, 1'b0);
    repeat (4) @(negedge clk_i);
    model_frame(8'h5A, 1'b1, 1'b1);
    @(negedge clk_i);
    fork
      send_frame(8'hF0, 1'b1, BIT_NS, 1'b0);
      begin
        #(4 * BIT_NS + 110);
        rst_ni = 1'b0;
        #1;
        check_eq("t5.rst_data",  data_o,      8'h00);
        check_eq("t5.rst_valid", valid_o,     1'b0);
        check_eq("t5.rst_ovr",   overrun_o,   1'b0);
        check_eq("t5.rst_fe",    frame_err_o, 1'b0);
        check_eq("t5.rst_busy",  busy_o,      1'b0);
        #99;
        rst_ni = 1'b1;
      end
    join
    model_reset();
    repeat (DIV * 3) @(negedge clk_i);
    check_outputs("t5.after");
    send_frame(8'h0F, 1'b1, BIT_NS, 1'b0);
    repeat (4) @(negedge clk_i);
    model_frame(8'h0F, 1'b1, 1'b1);
    check_outputs("t5.rx");
    do_ack();

    // ---- +/-3% baud tolerance ----
    for (int r = 0; r < 2; r++) begin
      for (int v = 0; v < 2; v++) begin
        bns = (r == 0) ? (BIT_NS * 103) / 100 : (BIT_NS * 97) / 100;
        b   = (v == 0) ? 8'h00 : 8'hFF;
        send_frame(b, 1'b1, bns, 1'b0);
        repeat (6) @(negedge clk_i);
        model_frame(b, 1'b1, 1'b1);
        check_outputs($sformatf("t6.tol%0d_%02h", bns, b));
        do_ack();
      end
    end

`ifdef UART_RX_PARITY_EN
    // ---- parity: 0x07 with parity bit 0 (wrong) then 1 (right) ----
    send_frame(8'h07, 1'b1, BIT_NS, 1'b1);
    repeat (4) @(negedge clk_i);
    model_frame(8'h07, 1'b1, 1'b0);
    check_outputs("t7.bad_par");
    do_ack();
    send_frame(8'h07, 1'b1, BIT_NS, 1'b0);
    repeat (4) @(negedge clk_i);
    model_frame(8'h07, 1'b1, 1'b1);
    check_outputs("t7.good_par");
    do_ack();
`endif

    // ---- randomized frames ----
    for (int it = 0; it < 24; it++) begin
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
      bns     = BIT_NS - 13 + int'($urandom_range(0, 26));
`ifdef UART_RX_PARITY_EN
      flip    = ($urandom_range(0, 3) == 0);
`else
      flip    = 1'b0;
`endif
      send_frame(b, stop_ok, bns, flip);
      if (!stop_ok) begin
        #(CLK_NS * int'($urandom_range(0, 30)));
        uart_rx_i = 1'b1;
      end
      #(CLK_NS * 6);
      model_frame(b, stop_ok, !flip);
      check_outputs($sformatf("rnd%0d", it));
      if ($urandom_range(0, 1) == 1) do_ack();
      #(CLK_NS * int'($urandom_range(0, 10)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
